// File: rtl/bg_pkg.sv
// Shared types, constants and lookup helpers for the bg_scroller background renderer.
// Star table constants exist only when BG_STARS_EN is defined.
package bg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } bg_state_t;

    localparam int MOUND_X0      = 306;
    localparam int MOUND_W       = 64;
    localparam int CLOUD_W       = 20;
    localparam int CLOUD_H       = 8;
    localparam int CLOUD_X0      = 140;
    localparam int CLOUD_DY_EVEN = 156;
    localparam int CLOUD_DY_ODD  = 136;

    // MSB is the leftmost sprite column.
    localparam logic [CLOUD_W-1:0] CLOUD_ROWS [CLOUD_H] = '{
        20'b00000011111100000000,
        20'b00001111111111000000,
        20'b00111111111111110000,
        20'b01111111111111111100,
        20'b11111111111111111111,
        20'b11111111111111111111,
        20'b01111111111111111110,
        20'b00011111111111111000
    };

`ifdef BG_STARS_EN
    localparam int STAR_ARM = 2;
    localparam int N_STARS  = 6;
    localparam logic [9:0] STAR_X [N_STARS] = '{10'd47,  10'd190, 10'd333, 10'd511, 10'd702, 10'd905};
    localparam logic [9:0] STAR_Y [N_STARS] = '{10'd448, 10'd405, 10'd430, 10'd390, 10'd452, 10'd415};
`endif

    // Symmetric 7-level lift over the 64-px mound; mx is the offset into the mound.
    function automatic logic [2:0] mound_lift(input logic [5:0] mx);
        logic [4:0] d;
        d = mx[5] ? ~mx[4:0] : mx[4:0];
        case (d[4:2])
            3'd0:    mound_lift = 3'd0;
            3'd1:    mound_lift = 3'd1;
            3'd2:    mound_lift = 3'd2;
            3'd3:    mound_lift = 3'd3;
            3'd4:    mound_lift = 3'd4;
            3'd5:    mound_lift = 3'd5;
            default: mound_lift = 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/bg_scroller_if.sv
// Pixel-path bundle between the VGA timing generator, bg_scroller and the overlay mixer.
interface bg_scroller_if #(
    parameter int COLOR_W = 2
);
    logic               video_active;
    logic [9:0]         pix_x;
    logic [9:0]         pix_y;
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;

    modport master (output video_active, pix_x, pix_y, input R, G, B);
    modport slave  (input video_active, pix_x, pix_y, output R, G, B);
endinterface

// File: rtl/bg_frame_ctrl.sv
// Frame-rate control: vsync synchroniser and edge detect, run/pause FSM, scroll and
// cloud counters, plus the star twinkle phase when BG_STARS_EN is defined.
module bg_frame_ctrl
    import bg_pkg::*;
#(
    parameter int H_RES          = 1024,
    parameter int SPEED_W        = 3,
    parameter int TWINKLE_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               start,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed,
    output logic               frame_tick,
    output bg_state_t          state,
    output logic [9:0]         scroll_pos,
    output logic [9:0]         cloud_off
`ifdef BG_STARS_EN
    ,
    output logic               twinkle
`endif
);

    logic      vs_s1, vs_s2, vs_s3;
    bg_state_t state_next;
    logic      advance, clear;
    logic      cloud_half;

    function automatic logic [9:0] wrap_add(input logic [9:0] base, input logic [SPEED_W-1:0] step);
        logic [10:0] sum;
        sum = {1'b0, base} + 11'(step);
        if (sum >= 11'(H_RES)) sum = sum - 11'(H_RES);
        return sum[9:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_s3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= vsync;
            vs_s2      <= vs_s1;
            vs_s3      <= vs_s2;
            frame_tick <= vs_s2 & ~vs_s3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Counters follow the state being entered, so the first RUN tick already scrolls.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        clear      = 1'b0;
        if (frame_tick) begin
            if (!start) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE:    state_next = RUN;
                    RUN:     if (pause) state_next = PAUSED;
                    PAUSED:  if (!pause) state_next = RUN;
                    default: state_next = IDLE;
                endcase
            end
            advance = (state_next == RUN);
            clear   = (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_pos <= '0;
            cloud_off  <= '0;
            cloud_half <= 1'b0;
        end else if (clear) begin
            scroll_pos <= '0;
            cloud_off  <= '0;
            cloud_half <= 1'b0;
        end else if (advance) begin
            scroll_pos <= wrap_add(scroll_pos, speed);
            cloud_half <= ~cloud_half;
            if (cloud_half) cloud_off <= wrap_add(cloud_off, speed);
        end
    end

`ifdef BG_STARS_EN
    localparam int TW_W = $clog2(TWINKLE_FRAMES + 1);
    logic [TW_W-1:0] tw_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_cnt  <= '0;
            twinkle <= 1'b0;
        end else if (advance) begin
            if (tw_cnt == TW_W'(TWINKLE_FRAMES - 1)) begin
                tw_cnt  <= '0;
                twinkle <= ~twinkle;
            end else begin
                tw_cnt <= tw_cnt + TW_W'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/bg_scroller.sv
// Scrolling night-sky background (horizon, mound, ground dots, clouds, optional stars)
// with a fixed 2-clk colour pipeline. Define BG_STARS_EN to build the star layer.
module bg_scroller
    import bg_pkg::*;
#(
    parameter int H_RES          = 1024,
    parameter int V_RES          = 768,
    parameter int GROUND_Y       = 628,
    parameter int N_CLOUDS       = 2,
    parameter int SPEED_W        = 3,
    parameter int TWINKLE_FRAMES = 8,
    parameter int COLOR_W        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               start,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed,
    output logic [9:0]         scroll_pos,
    output logic               frame_tick,
    bg_scroller_if.slave       pix
);

    bg_state_t          state;
    logic [9:0]         cloud_off;
    logic [9:0]         ground_x, mound_x;
    logic [2:0]         lift;
    logic               line_hit, dot_hit, cloud_hit, star_hit;
    logic               hit_p0, vld_p0;
    logic               hit_p1, vld_p1;
    logic [COLOR_W-1:0] color_p2;
`ifdef BG_STARS_EN
    logic               twinkle;
`endif

    bg_frame_ctrl #(
        .H_RES          (H_RES),
        .SPEED_W        (SPEED_W),
        .TWINKLE_FRAMES (TWINKLE_FRAMES)
    ) u_frame_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .start      (start),
        .pause      (pause),
        .speed      (speed),
        .frame_tick (frame_tick),
        .state      (state),
        .scroll_pos (scroll_pos),
        .cloud_off  (cloud_off)
`ifdef BG_STARS_EN
        ,
        .twinkle    (twinkle)
`endif
    );

    function automatic logic [9:0] wrap_h(input logic [12:0] v);
        logic [12:0] r;
        r = v;
        for (int k = 0; k < 3; k++) begin
            if (r >= 13'(H_RES)) r = r - 13'(H_RES);
        end
        return r[9:0];
    endfunction

    function automatic logic cloud_at(input int idx, input logic [9:0] px,
                                      input logic [9:0] py, input logic [9:0] off);
        logic [9:0]         cx, dx;
        logic signed [11:0] dy;
        logic [CLOUD_W-1:0] row;
        logic [4:0]         rc;
        cx  = wrap_h(13'(CLOUD_X0 + idx * (H_RES / N_CLOUDS)) + 13'(H_RES) - 13'(off));
        dx  = wrap_h(13'(px) + 13'(H_RES) - 13'(cx));
        dy  = $signed({2'b00, py})
            - $signed(12'(idx[0] ? GROUND_Y - CLOUD_DY_ODD : GROUND_Y - CLOUD_DY_EVEN));
        row = CLOUD_ROWS[dy[3:1]];
        rc  = dx[5:1];
        cloud_at = 1'b0;
        if (dx < 10'(2 * CLOUD_W) && !dy[11] && dy < $signed(12'(2 * CLOUD_H)))
            cloud_at = row[5'(CLOUD_W - 1) - rc];
    endfunction

`ifdef BG_STARS_EN
    // Plus shape when plus=1, diagonal cross otherwise; stars are fixed in screen space.
    function automatic logic star_at(input logic [9:0] px, input logic [9:0] py, input logic plus);
        logic signed [10:0] dx, dy;
        logic [10:0]        ax, ay;
        star_at = 1'b0;
        for (int s = 0; s < N_STARS; s++) begin
            dx = $signed({1'b0, px}) - $signed({1'b0, STAR_X[s]});
            dy = $signed({1'b0, py}) - $signed({1'b0, STAR_Y[s]});
            ax = dx[10] ? -dx : dx;
            ay = dy[10] ? -dy : dy;
            if (plus) begin
                if ((ax == '0 && ay <= 11'(STAR_ARM)) || (ay == '0 && ax <= 11'(STAR_ARM)))
                    star_at = 1'b1;
            end else if (ax == ay && ax <= 11'(STAR_ARM)) begin
                star_at = 1'b1;
            end
        end
    endfunction
`endif

    // Stage 0: layer hit tests from the incoming pixel coordinate.
    always_comb begin
        ground_x = wrap_h(13'(pix.pix_x) + 13'(scroll_pos));
        mound_x  = wrap_h(13'(pix.pix_x) + 13'(scroll_pos) + 13'(H_RES - MOUND_X0));
        lift     = (mound_x < 10'(MOUND_W)) ? mound_lift(mound_x[5:0]) : 3'd0;
        line_hit = ({1'b0, pix.pix_y} + 11'(lift)) == 11'(GROUND_Y);
        dot_hit  = (pix.pix_y == 10'(GROUND_Y + 3) && (ground_x % 10'd8)  == 10'd2)
                || (pix.pix_y == 10'(GROUND_Y + 5) && (ground_x % 10'd11) == 10'd4)
                || (pix.pix_y == 10'(GROUND_Y + 7) && (ground_x % 10'd17) == 10'd9);
        cloud_hit = 1'b0;
        for (int i = 0; i < N_CLOUDS; i++)
            cloud_hit = cloud_hit | cloud_at(i, pix.pix_x, pix.pix_y, cloud_off);
`ifdef BG_STARS_EN
        star_hit = star_at(pix.pix_x, pix.pix_y, twinkle);
`else
        star_hit = 1'b0;
`endif
        // Every layer paints all-ones, so the layer priority collapses to an OR.
        hit_p0 = line_hit | dot_hit | cloud_hit | star_hit;
        vld_p0 = pix.video_active && (state != IDLE) && ({1'b0, pix.pix_y} < 11'(V_RES));
    end

    // Stage 1: registered hit flag and visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            hit_p1 <= hit_p0;
            vld_p1 <= vld_p0;
        end
    end

    // Stage 2: registered monochrome colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) color_p2 <= '0;
        else        color_p2 <= (vld_p1 && hit_p1) ? '1 : '0;
    end

    assign pix.R = color_p2;
    assign pix.G = color_p2;
    assign pix.B = color_p2;

endmodule

// File: tb/tb_bg_scroller.sv
// Directed self-checking bench for bg_scroller: frame timing, scrolling, wrap,
// pause/stop, pixel pipeline latency, mound, dots, clouds and star twinkle.
module tb_bg_scroller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       start;
    logic       pause;
    logic [2:0] speed;
    logic [9:0] scroll_pos;
    logic       frame_tick;
    int         checks   = 0;
    int         failures = 0;

`ifdef BG_STARS_EN
    localparam logic [1:0] STAR_ON = 2'b11;
`else
    localparam logic [1:0] STAR_ON = 2'b00;
`endif

    bg_scroller_if #(.COLOR_W(2)) pix_bus ();

    bg_scroller #(
        .H_RES(1024), .V_RES(768), .GROUND_Y(628), .N_CLOUDS(2),
        .SPEED_W(3), .TWINKLE_FRAMES(8), .COLOR_W(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .start      (start),
        .pause      (pause),
        .speed      (speed),
        .scroll_pos (scroll_pos),
        .frame_tick (frame_tick),
        .pix        (pix_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic [1:0] exp);
        chk(tag, 11'({pix_bus.R, pix_bus.G, pix_bus.B}), 11'({exp, exp, exp}));
    endtask

    task automatic drive_pix(input int x, input int y, input logic va);
        pix_bus.pix_x        = 10'(x);
        pix_bus.pix_y        = 10'(y);
        pix_bus.video_active = va;
    endtask

    task automatic expect_pixel(input string tag, input int x, input int y,
                                input logic va, input logic [1:0] exp);
        drive_pix(x, y, va);
        step();
        step();
        chk_rgb(tag, exp);
    endtask

    // One vsync pulse; tick must appear on the 3rd edge, scroll must move on the 4th.
    task automatic pulse(input logic [9:0] exp_old, input logic [9:0] exp_new, input bit do_chk);
        vsync = 1'b1;
        step();
        step();
        if (do_chk) chk("tick_early", 11'(frame_tick), 11'd0);
        step();
        if (do_chk) begin
            chk("tick_high", 11'(frame_tick), 11'd1);
            chk("scroll_hold_on_tick", 11'(scroll_pos), 11'(exp_old));
        end
        step();
        if (do_chk) begin
            chk("tick_one_clk", 11'(frame_tick), 11'd0);
            chk("scroll_after_tick", 11'(scroll_pos), 11'(exp_new));
        end
        vsync = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        speed = 3'd0;
        drive_pix(0, 628, 1'b1);

        for (int i = 0; i < 6; i++) begin
            vsync = ~vsync;
            step();
            chk("rst_tick", 11'(frame_tick), 11'd0);
        end
        chk("rst_scroll", 11'(scroll_pos), 11'd0);
        chk_rgb("rst_rgb", 2'b00);
        vsync = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        expect_pixel("idle_black", 0, 628, 1'b1, 2'b00);

        start = 1'b1;
        pulse(10'd0, 10'd0, 1'b1);

        expect_pixel("sky_black", 5, 100, 1'b1, 2'b00);
        drive_pix(0, 628, 1'b1);
        step();
        chk_rgb("latency_1clk", 2'b00);
        step();
        chk_rgb("ground_line", 2'b11);
        expect_pixel("ground_va0", 0, 628, 1'b0, 2'b00);
        expect_pixel("mound_peak", 338, 622, 1'b1, 2'b11);
        expect_pixel("mound_base", 338, 628, 1'b1, 2'b00);
        expect_pixel("dot_mod8", 2, 631, 1'b1, 2'b11);
        expect_pixel("dot_miss", 3, 631, 1'b1, 2'b00);
        expect_pixel("cloud_body", 160, 480, 1'b1, 2'b11);
        expect_pixel("cloud_corner", 140, 472, 1'b1, 2'b00);

        expect_pixel("pre_reset", 0, 628, 1'b1, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk_rgb("async_reset", 2'b00);
        #2 rst_n = 1'b1;
        step();
        chk_rgb("post_reset", 2'b00);
        pulse(10'd0, 10'd0, 1'b1);

        speed = 3'd3;
        pulse(10'd0, 10'd3, 1'b1);
        pulse(10'd3, 10'd6, 1'b1);
        pulse(10'd6, 10'd9, 1'b1);
        pulse(10'd9, 10'd12, 1'b1);

        speed = 3'd7;
        for (int i = 0; i < 144; i++) pulse(10'd0, 10'd0, 1'b0);
        speed = 3'd2;
        pulse(10'd1020, 10'd1022, 1'b1);
        speed = 3'd0;
        pulse(10'd1022, 10'd1022, 1'b1);
        speed = 3'd4;
        pulse(10'd1022, 10'd2, 1'b1);

        pause = 1'b1;
        for (int i = 0; i < 3; i++) pulse(10'd2, 10'd2, 1'b1);
        pause = 1'b0;
        pulse(10'd2, 10'd6, 1'b1);
        start = 1'b0;
        pause = 1'b1;
        pulse(10'd6, 10'd0, 1'b1);
        expect_pixel("stopped_black", 0, 628, 1'b1, 2'b00);

        pause = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1;
        speed = 3'd1;
        for (int i = 0; i < 7; i++) pulse(10'd0, 10'd0, 1'b0);
        chk("scroll_after_7", 11'(scroll_pos), 11'd7);
        expect_pixel("star_centre_ph0", 47, 448, 1'b1, STAR_ON);
        expect_pixel("star_arm_ph0", 47, 446, 1'b1, 2'b00);
        expect_pixel("star_diag_ph0", 49, 450, 1'b1, STAR_ON);

        pause = 1'b1;
        for (int i = 0; i < 3; i++) pulse(10'd7, 10'd7, 1'b1);
        expect_pixel("star_arm_paused", 47, 446, 1'b1, 2'b00);
        expect_pixel("star_diag_paused", 49, 450, 1'b1, STAR_ON);

        pause = 1'b0;
        pulse(10'd7, 10'd8, 1'b1);
        expect_pixel("star_arm_ph1", 47, 446, 1'b1, STAR_ON);
        expect_pixel("star_centre_ph1", 47, 448, 1'b1, STAR_ON);
        expect_pixel("star_diag_ph1", 49, 450, 1'b1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
